// File: rtl/int_ctrl.sv
// Multi-channel interrupt controller: latches, masks and prioritises N_IRQ sources
// into a single Ireq/Iack handshake, then blocks new requests until eret.
module int_ctrl #(
  parameter int   N_IRQ        = 8,
  parameter int   ID_W         = 3,
  parameter logic EDGE_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             int_en,
  output logic             Ireq,
  input  logic             Iack,
  input  logic             eret,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_active,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_MASK   = 2'd0;
  localparam logic [1:0] A_MODE   = 2'd1;
  localparam logic [1:0] A_PEND   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t           r_state;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_prev;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_pend_eff;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_clr;
  logic [ID_W-1:0]  w_win;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;
  logic             w_ack;

  assign w_ack = (r_state == S_REQ) && Iack;

  // Level channels bypass the latch entirely; edge channels use the sticky PEND bit.
  always_comb begin
    w_rise     = irq_in & ~r_prev & r_mode;
    w_pend_eff = (r_mode & r_pend) | (~r_mode & irq_in);
    w_elig     = w_pend_eff & r_mask;
  end

  // Descending scan so the lowest eligible index is the final assignment.
  always_comb begin
    w_win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    if (reg_we && reg_addr == A_PEND) w_clr = reg_wdata[N_IRQ-1:0];
    for (int i = 0; i < N_IRQ; i++) begin
      if (w_ack && irq_id == ID_W'(i)) w_clr[i] = 1'b1;
    end
    w_clr = w_clr & r_mode;
  end

  always_comb begin
    w_status             = '0;
    w_status[31]         = irq_active;
    w_status[9:8]        = r_state;
    w_status[ID_W-1:0]   = irq_id;
    w_rdata              = '0;
    case (reg_addr)
      A_MASK:   w_rdata[N_IRQ-1:0] = r_mask;
      A_MODE:   w_rdata[N_IRQ-1:0] = r_mode;
      A_PEND:   w_rdata[N_IRQ-1:0] = w_pend_eff;
      A_STATUS: w_rdata            = w_status;
      default:  w_rdata            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_mode     <= {N_IRQ{EDGE_DEFAULT}};
      r_pend     <= '0;
      r_prev     <= '0;
      Ireq       <= 1'b0;
      irq_id     <= '0;
      irq_active <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      r_prev    <= irq_in;
      // A new edge in the same cycle as its clear must not be lost.
      r_pend    <= (r_pend & ~w_clr) | w_rise;
      reg_rdata <= w_rdata;
      if (reg_we && reg_addr == A_MASK) r_mask <= reg_wdata[N_IRQ-1:0];
      if (reg_we && reg_addr == A_MODE) r_mode <= reg_wdata[N_IRQ-1:0];
      case (r_state)
        S_IDLE: begin
          if (int_en && |w_elig) begin
            irq_id  <= w_win;
            Ireq    <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // No withdrawal: the control unit may already be committing to the trap.
          if (Iack) begin
            Ireq       <= 1'b0;
            irq_active <= 1'b1;
            r_state    <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (eret) begin
            irq_active <= 1'b0;
            irq_id     <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scenario-driven bench for int_ctrl; expected ids/readbacks are queued at stimulus
// time and popped when the DUT response is observed.
module tb_int_ctrl;
  localparam int N_IRQ = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_IRQ-1:0] irq_in = '0;
  logic             int_en = 1'b0;
  logic             Ireq;
  logic             Iack = 1'b0;
  logic             eret = 1'b0;
  logic [ID_W-1:0]  irq_id;
  logic             irq_active;
  logic             reg_we = 1'b0;
  logic [1:0]       reg_addr = 2'd0;
  logic [31:0]      reg_wdata = '0;
  logic [31:0]      reg_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  int_ctrl #(.N_IRQ(N_IRQ), .ID_W(ID_W), .EDGE_DEFAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_en(int_en), .Ireq(Ireq),
    .Iack(Iack), .eret(eret), .irq_id(irq_id), .irq_active(irq_active),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    tick();
    d = reg_rdata;
  endtask

  task automatic pulse_iack();
    Iack = 1'b1; tick(); Iack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests++; if ({Ireq, irq_active, irq_id} !== '0) begin n_fail++; $display("FAIL reset_outs got Ireq=%b act=%b id=%0d exp all 0", Ireq, irq_active, irq_id); end
    n_tests++; if (reg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", reg_rdata); end
    exp_q.push_back(32'hFF); reg_read(2'd1, v);
    n_tests++; if (v !== 32'(exp_q.pop_front())) begin n_fail++; $display("FAIL reset_mode got %h exp ff", v); end
    exp_q.push_back(0); reg_read(2'd0, v);
    n_tests++; if (v !== 32'(exp_q.pop_front())) begin n_fail++; $display("FAIL reset_mask got %h exp 0", v); end
    exp_q.push_back(0); reg_read(2'd3, v);
    n_tests++; if (v !== 32'(exp_q.pop_front())) begin n_fail++; $display("FAIL reset_status got %h exp 0", v); end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    int e;
    reg_write(2'd0, 32'hFF); int_en = 1'b1;
    irq_in = 8'h20; exp_q.push_back(5); tick(); irq_in = '0;
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL basic_early got Ireq=%b exp 0", Ireq); end
    tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL basic_req got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack();
    n_tests++; if (Ireq !== 1'b0 || irq_active !== 1'b1) begin n_fail++; $display("FAIL basic_ack got Ireq=%b act=%b exp 0 1", Ireq, irq_active); end
    reg_read(2'd2, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL basic_pend got %h exp 0", v); end
    pulse_eret();
    n_tests++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL basic_eret got act=%b exp 0", irq_active); end
    reg_read(2'd3, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL basic_status got %h exp 0", v); end
  endtask

  task automatic test_priority();
    int e;
    irq_in = 8'h44; exp_q.push_back(2); exp_q.push_back(6); tick(); irq_in = '0; tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL prio_first got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); pulse_eret();
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap got Ireq=%b exp 0", Ireq); end
    tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL prio_second got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); pulse_eret();
  endtask

  task automatic test_mask_w1c();
    logic [31:0] v;
    int e;
    reg_write(2'd0, 32'h00);
    irq_in = 8'h08; tick(); irq_in = '0; tick(); tick();
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL mask_blocked got Ireq=%b exp 0", Ireq); end
    reg_read(2'd2, v);
    n_tests++; if (v !== 32'h08) begin n_fail++; $display("FAIL mask_pend got %h exp 08", v); end
    exp_q.push_back(3);
    reg_write(2'd0, 32'h08);
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_early got Ireq=%b exp 0", Ireq); end
    tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL mask_unmask got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); pulse_eret();
    reg_write(2'd0, 32'h00);
    irq_in = 8'h08; tick(); irq_in = '0; tick();
    reg_write(2'd2, 32'h08);
    reg_read(2'd2, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL w1c_pend got %h exp 0", v); end
    reg_write(2'd0, 32'h08); tick(); tick();
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL w1c_noreq got Ireq=%b exp 0", Ireq); end
    reg_write(2'd0, 32'hFF);
  endtask

  task automatic test_level();
    int e;
    reg_write(2'd1, 32'hFD);
    irq_in = 8'h02; exp_q.push_back(1); exp_q.push_back(1); tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL level_req got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); pulse_eret(); tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL level_rereq got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); irq_in = '0; pulse_eret(); tick(); tick();
    n_tests++; if (Ireq !== 1'b0) begin n_fail++; $display("FAIL level_dropped got Ireq=%b exp 0", Ireq); end
    reg_write(2'd1, 32'hFF);
  endtask

  task automatic test_no_withdraw();
    logic [31:0] v;
    int e;
    irq_in = 8'h10; exp_q.push_back(4); exp_q.push_back(4); tick(); irq_in = '0; tick();
    int_en = 1'b0; reg_write(2'd0, 32'h00); tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL hold_req got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    irq_in = 8'h10; pulse_iack();
    n_tests++; if (Ireq !== 1'b0 || irq_active !== 1'b1) begin n_fail++; $display("FAIL hold_ack got Ireq=%b act=%b exp 0 1", Ireq, irq_active); end
    reg_read(2'd2, v);
    n_tests++; if (v !== 32'h10) begin n_fail++; $display("FAIL set_wins got %h exp 10", v); end
    irq_in = '0; int_en = 1'b1; reg_write(2'd0, 32'hFF);
    pulse_eret(); tick();
    e = exp_q.pop_front();
    n_tests++; if (Ireq !== 1'b1 || irq_id !== ID_W'(e)) begin n_fail++; $display("FAIL set_wins_req got Ireq=%b id=%0d exp 1 id=%0d", Ireq, irq_id, e); end
    pulse_iack(); pulse_eret();
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    irq_in = 8'h01; tick(); irq_in = '0; tick();
    n_tests++; if (Ireq !== 1'b1) begin n_fail++; $display("FAIL rst_req_setup got Ireq=%b exp 1", Ireq); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (Ireq !== 1'b0 || irq_active !== 1'b0 || irq_id !== '0) begin n_fail++; $display("FAIL rst_in_req got Ireq=%b act=%b id=%0d exp 0 0 0", Ireq, irq_active, irq_id); end
    reg_read(2'd0, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mask got %h exp 0", v); end
    reg_write(2'd0, 32'hFF);
    irq_in = 8'h80; tick(); irq_in = '0; tick(); pulse_iack();
    irq_in = 8'h08; tick(); irq_in = '0;
    n_tests++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL rst_svc_setup got act=%b exp 1", irq_active); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if (Ireq !== 1'b0 || irq_active !== 1'b0) begin n_fail++; $display("FAIL rst_in_svc got Ireq=%b act=%b exp 0 0", Ireq, irq_active); end
    reg_read(2'd2, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_pend got %h exp 0", v); end
    reg_write(2'd0, 32'hFF); pulse_eret();
    reg_read(2'd3, v);
    n_tests++; if (v !== 32'h0 || Ireq !== 1'b0) begin n_fail++; $display("FAIL idle_eret got status=%h Ireq=%b exp 0 0", v, Ireq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_w1c();
    test_level();
    test_no_withdraw();
    test_reset_mid();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
